// File: rtl/fifo_reader_pkg.sv
// ============================================================================
// Module   : fifo_reader_pkg
// Brief    : Shared state encoding and default widths for the sample reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_reader_pkg;

    localparam int c_DATA_SIZE = 12;
    localparam int c_LEN_SIZE  = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_sample_reader_trig_detect.sv
// ============================================================================
// Module   : trig_detect
// Brief    : Holds the previous kept sample and flags a level crossing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_detect
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE = c_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_sample_en,
    input  logic [DATA_SIZE-1:0] i_cur,
    input  logic [DATA_SIZE-1:0] i_level,
    input  logic                 i_rising,
    output logic                 o_hit
);

    logic [DATA_SIZE-1:0] r_prev;
    logic                 r_prev_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clr) begin
            r_prev_valid <= 1'b0;
        end else if (i_sample_en) begin
            r_prev       <= i_cur;
            r_prev_valid <= 1'b1;
        end
    end

    always_comb begin
        o_hit = 1'b0;
        if (r_prev_valid) begin
            if (i_rising)
                o_hit = (r_prev < i_level) && (i_cur >= i_level);
            else
                o_hit = (r_prev > i_level) && (i_cur <= i_level);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_sample_reader.sv
// ============================================================================
// Module   : fifo_sample_reader
// Brief    : FIFO read-side consumer: drain, level trigger, framed capture.
//            Optional decimation enabled by FIFO_READER_DECIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sample_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE = c_DATA_SIZE,
    parameter int LEN_SIZE  = c_LEN_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_SIZE-1:0] fifo_data_i,
    output logic                 fifo_inc_o,
    input  logic                 arm_i,
    input  logic [DATA_SIZE-1:0] trig_level_i,
    input  logic                 trig_rising_i,
    input  logic [LEN_SIZE-1:0]  capture_len_i,
`ifdef FIFO_READER_DECIM_EN
    input  logic [7:0]           decim_i,
`endif
    output logic [DATA_SIZE-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o,
    output logic                 busy_o,
    output logic                 triggered_o
);

    localparam logic [LEN_SIZE:0] c_ONE = {{LEN_SIZE{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic [LEN_SIZE-1:0]   r_len;
    logic [DATA_SIZE-1:0]  r_level;
    logic                  r_rising;
    logic [LEN_SIZE:0]     r_count;
    logic [LEN_SIZE:0]     w_count_inc;
    logic [DATA_SIZE-1:0]  r_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  w_arm;
    logic                  w_keep;
    logic                  w_pop;
    logic                  w_take;
    logic                  w_load;
    logic                  w_hit;
    logic                  w_done;

    assign w_arm       = (r_state == IDLE) && arm_i && (capture_len_i != '0);
    assign w_count_inc = r_count + c_ONE;
    assign w_done      = (r_count == {1'b0, r_len});
    assign w_take      = w_pop && w_keep && (r_state != IDLE);
    assign w_load      = w_take && ((r_state == CAPTURE) || w_hit);

`ifdef FIFO_READER_DECIM_EN
    logic [7:0] r_decim;
    logic [7:0] r_phase;

    // Phase 0 is the kept slot, so the first pop after arming is kept.
    assign w_keep = (r_phase == 8'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_decim <= 8'd0;
            r_phase <= 8'd0;
        end else if (w_arm) begin
            r_decim <= decim_i;
            r_phase <= 8'd0;
        end else if ((r_state != IDLE) && w_pop) begin
            r_phase <= (r_phase == r_decim) ? 8'd0 : r_phase + 8'd1;
        end
    end
`else
    assign w_keep = 1'b1;
`endif

    // Discarded samples never need the output slot, only kept ones do.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE, ARMED: w_pop = !fifo_empty_i;
            CAPTURE:     w_pop = !fifo_empty_i && !w_done &&
                                 (!w_keep || !r_valid || m_ready_i);
            default:     w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_arm)                          w_state_next = ARMED;
            ARMED:   if (w_take && w_hit)                w_state_next = CAPTURE;
            CAPTURE: if (r_valid && m_ready_i && r_last) w_state_next = IDLE;
            default:                                     w_state_next = IDLE;
        endcase
    end

    // Count is zero while armed, so the trigger sample takes count 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len    <= '0;
            r_level  <= '0;
            r_rising <= 1'b0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            if (w_arm) begin
                r_len    <= capture_len_i;
                r_level  <= trig_level_i;
                r_rising <= trig_rising_i;
                r_count  <= '0;
            end
            if (w_load) begin
                r_data  <= fifo_data_i;
                r_valid <= 1'b1;
                r_last  <= (w_count_inc == {1'b0, r_len});
                r_count <= w_count_inc;
            end else if (r_valid && m_ready_i) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    trig_detect #(
        .DATA_SIZE (DATA_SIZE)
    ) u_trig_detect (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_clr       (w_arm),
        .i_sample_en (w_take && (r_state == ARMED)),
        .i_cur       (fifo_data_i),
        .i_level     (r_level),
        .i_rising    (r_rising),
        .o_hit       (w_hit)
    );

    assign fifo_inc_o  = w_pop;
    assign m_data_o    = r_data;
    assign m_valid_o   = r_valid;
    assign m_last_o    = r_last;
    assign busy_o      = (r_state != IDLE);
    assign triggered_o = (r_state == CAPTURE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_sample_reader.sv
// ============================================================================
// Module   : tb_fifo_sample_reader
// Brief    : Scoreboard bench for fifo_sample_reader with a queue FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_sample_reader;
    import fifo_reader_pkg::*;

    localparam int DW = 12;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_inc_o;
    logic          arm_i;
    logic [DW-1:0] trig_level_i;
    logic          trig_rising_i;
    logic [LW-1:0] capture_len_i;
    logic [7:0]    decim_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;
    logic          busy_o;
    logic          triggered_o;

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    fifo_sample_reader dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_inc_o    (fifo_inc_o),
        .arm_i         (arm_i),
        .trig_level_i  (trig_level_i),
        .trig_rising_i (trig_rising_i),
        .capture_len_i (capture_len_i),
`ifdef FIFO_READER_DECIM_EN
        .decim_i       (decim_i),
`endif
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_last_o      (m_last_o),
        .busy_o        (busy_o),
        .triggered_o   (triggered_o)
    );

    task automatic refresh_fifo();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        refresh_fifo();
    endtask

    task automatic expect_word(input logic [DW-1:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    // One clock: sample handshakes just before the edge, update FIFO model after.
    task automatic tick();
        logic        pop;
        logic        xfer;
        logic [DW:0] got;
        logic [DW:0] exp;
        #1;
        pop  = fifo_inc_o && !fifo_empty_i;
        xfer = m_valid_o && m_ready_i;
        got  = {m_last_o, m_data_o};
        if (triggered_o && m_valid_o && !m_ready_i) begin
            n_cmp++;
            if (fifo_inc_o !== 1'b0) begin
                n_err++;
                $display("FAIL stall_pop: fifo_inc_o=%b required 0", fifo_inc_o);
            end
        end
        if (xfer === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL extra_output: got last=%b data=%h required none", got[DW], got[DW-1:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL frame_word: got last=%b data=%h required last=%b data=%h",
                             got[DW], got[DW-1:0], exp[DW], exp[DW-1:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (pop === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic arm_cmd(input logic [DW-1:0] level, input logic rising, input logic [LW-1:0] len);
        trig_level_i  = level;
        trig_rising_i = rising;
        capture_len_i = len;
        arm_i         = 1'b1;
        tick();
        arm_i         = 1'b0;
    endtask

    task automatic run_frame(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: busy_o=%b required 0", name, busy_o);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({m_valid_o, m_last_o, busy_o, triggered_o, fifo_inc_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 00000", {m_valid_o, m_last_o, busy_o, triggered_o, fifo_inc_o});
        end
        n_cmp++;
        if (m_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 000", m_data_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_idle_drain();
        for (int i = 0; i < 5; i++) push_word(DW'(12'h100 + i));
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({fifo_inc_o, m_valid_o, busy_o} !== 3'b100) begin
                n_err++;
                $display("FAIL idle_drain: inc/valid/busy=%b required 100", {fifo_inc_o, m_valid_o, busy_o});
            end
            tick();
        end
        n_cmp++;
        if (fifo_q.size() != 0) begin
            n_err++;
            $display("FAIL idle_drain_empty: %0d words left, required 0", fifo_q.size());
        end
    endtask

    task automatic test_arm_ignored();
        arm_cmd(12'h010, 1'b1, '0);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL arm_len0: busy_o=%b required 0", busy_o);
        end
        rst_i = 1'b1;
        arm_cmd(12'h010, 1'b1, 10'd4);
        rst_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL arm_with_reset: busy_o=%b required 0", busy_o);
        end
    endtask

    task automatic test_rising();
        arm_cmd(12'h800, 1'b1, 10'd4);
        n_cmp++;
        if ({busy_o, triggered_o} !== 2'b10) begin
            n_err++;
            $display("FAIL rising_armed: busy/triggered=%b required 10", {busy_o, triggered_o});
        end
        expect_word(12'h800, 1'b0);
        expect_word(12'h900, 1'b0);
        expect_word(12'hA00, 1'b0);
        expect_word(12'hB00, 1'b1);
        push_word(12'h700); push_word(12'h7FF); push_word(12'h800);
        push_word(12'h900); push_word(12'hA00); push_word(12'hB00);
        run_frame("rising", 40);
    endtask

    task automatic test_falling();
        arm_cmd(12'h400, 1'b0, 10'd2);
        expect_word(12'h400, 1'b0);
        expect_word(12'h300, 1'b1);
        push_word(12'h500); push_word(12'h400); push_word(12'h300);
        run_frame("falling", 40);
    endtask

    task automatic test_len1();
        arm_cmd(12'h300, 1'b1, 10'd1);
        expect_word(12'h300, 1'b1);
        push_word(12'h100); push_word(12'h300); push_word(12'h400);
        run_frame("len1", 40);
    endtask

    task automatic test_backpressure();
        int n;
        arm_cmd(12'h100, 1'b1, 10'd8);
        push_word(12'h050);
        for (int i = 0; i < 8; i++) begin
            push_word(DW'(12'h100 + i));
            expect_word(DW'(12'h100 + i), i == 7);
        end
        n = 0;
        m_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            m_ready_i = ~m_ready_i;
            n++;
        end
        m_ready_i = 1'b1;
        run_frame("backpressure", 20);
    endtask

    task automatic test_empty_gap();
        arm_cmd(12'h200, 1'b1, 10'd6);
        for (int i = 0; i < 6; i++) expect_word(DW'(12'h200 + i), i == 5);
        push_word(12'h1F0);
        for (int i = 0; i < 3; i++) push_word(DW'(12'h200 + i));
        repeat (14) tick();
        n_cmp++;
        if ({m_valid_o, triggered_o} !== 2'b01) begin
            n_err++;
            $display("FAIL gap_stall: valid/triggered=%b required 01", {m_valid_o, triggered_o});
        end
        for (int i = 3; i < 6; i++) push_word(DW'(12'h200 + i));
        run_frame("empty_gap", 40);
    endtask

    task automatic test_reset_midframe();
        arm_cmd(12'h800, 1'b1, 10'd4);
        m_ready_i = 1'b0;
        push_word(12'h700); push_word(12'h900);
        repeat (4) tick();
        n_cmp++;
        if ({m_valid_o, triggered_o} !== 2'b11) begin
            n_err++;
            $display("FAIL midframe_hold: valid/triggered=%b required 11", {m_valid_o, triggered_o});
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_cmp++;
        if ({m_valid_o, m_last_o, busy_o} !== 3'b000) begin
            n_err++;
            $display("FAIL midframe_reset: valid/last/busy=%b required 000", {m_valid_o, m_last_o, busy_o});
        end
        push_word(12'h111); push_word(12'h222);
        #1;
        n_cmp++;
        if (fifo_inc_o !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_drain: fifo_inc_o=%b required 1", fifo_inc_o);
        end
        repeat (2) tick();
        n_cmp++;
        if (fifo_q.size() != 0) begin
            n_err++;
            $display("FAIL midframe_drained: %0d words left, required 0", fifo_q.size());
        end
        m_ready_i = 1'b1;
    endtask

`ifdef FIFO_READER_DECIM_EN
    task automatic test_decim();
        decim_i = 8'd1;
        arm_cmd(12'd10, 1'b1, 10'd3);
        expect_word(12'd10, 1'b0);
        expect_word(12'd12, 1'b0);
        expect_word(12'd14, 1'b1);
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        run_frame("decim", 60);
    endtask
`endif

    initial begin
        rst_i         = 1'b1;
        arm_i         = 1'b0;
        trig_level_i  = '0;
        trig_rising_i = 1'b0;
        capture_len_i = '0;
        decim_i       = 8'd0;
        m_ready_i     = 1'b1;
        refresh_fifo();
        test_reset();
        test_idle_drain();
        test_arm_ignored();
        test_rising();
        test_falling();
        test_len1();
        test_backpressure();
        test_empty_gap();
        test_reset_midframe();
`ifdef FIFO_READER_DECIM_EN
        test_decim();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_sample_reader.md
# fifo_sample_reader

Read-side consumer of the sample FIFO in the acquisition path; runs entirely in the FIFO read clock domain. Pops 12-bit ADC samples, searches for a level-crossing trigger once armed, then streams a fixed-length capture frame to the downstream display/transfer logic over a valid/ready handshake. While idle it drains the FIFO continuously so the write side never reports full.

## Interface
- DATA_SIZE, 12, sample width; must equal the FIFO data width
- LEN_SIZE, 10, width of the capture length
- clk_i  in  1  clock, the FIFO read clock
- rst_i  in  1  reset; synchronous, active-high
- fifo_empty_i  in  1  FIFO read-side empty flag
- fifo_data_i  in  DATA_SIZE  FIFO head word; valid whenever fifo_empty_i=0 (first-word-fall-through)
- fifo_inc_o  out  1  pop strobe; head is consumed on a cycle with fifo_inc_o=1
- arm_i  in  1  single-cycle arm request
- trig_level_i  in  DATA_SIZE  trigger threshold, unsigned
- trig_rising_i  in  1  1: rising-edge trigger, 0: falling-edge trigger
- capture_len_i  in  LEN_SIZE  number of samples per frame; 0 is not valid
- m_data_o  out  DATA_SIZE  output sample
- m_valid_o  out  1  output valid
- m_ready_i  in  1  downstream ready
- m_last_o  out  1  marks the final sample of a frame; qualified by m_valid_o
- busy_o  out  1  high in ARMED and CAPTURE
- triggered_o  out  1  high in CAPTURE
- decim_i  in  8  decimation factor minus one; present only with FIFO_READER_DECIM_EN

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE:
  - fifo_inc_o = !fifo_empty_i; popped samples are discarded.
  - arm_i=1 with capture_len_i!=0: latch capture_len_i, trig_level_i and trig_rising_i, clear prev_valid, go to ARMED.
  - arm_i with capture_len_i=0 is ignored. arm_i outside IDLE is ignored.
- ARMED:
  - fifo_inc_o = !fifo_empty_i.
  - Each popped sample updates prev, and the first one sets prev_valid.
  - Trigger condition, requiring prev_valid=1:
    - rising: prev < level and cur >= level
    - falling: prev > level and cur <= level
  - On a trigger, the triggering sample is loaded into the output register with count=1, and the state moves to CAPTURE.
- CAPTURE:
  - fifo_inc_o = !fifo_empty_i && (!m_valid_o || m_ready_i).
  - Each popped sample is loaded into the output register and the count increments.
  - m_last_o is registered with the sample and is high when count == latched length.
  - After the last sample is popped, fifo_inc_o stays 0.
  - The state returns to IDLE on the cycle the last sample transfers (m_valid_o && m_ready_i && m_last_o).
- Length of 1: the trigger sample carries m_last_o=1.
- Comparisons are unsigned and DATA_SIZE wide. count is LEN_SIZE+1 bits, so the maximum length 2^LEN_SIZE-1 does not wrap.

## Timing
- Reset values: fifo_inc_o=0, m_data_o=0, m_valid_o=0, m_last_o=0, busy_o=0, triggered_o=0, state IDLE, count=0, prev_valid=0.
- fifo_inc_o is combinational from state, fifo_empty_i, m_valid_o and m_ready_i.
- m_data_o, m_valid_o and m_last_o are registered.
- Latency: a sample popped in cycle N appears on m_valid_o in cycle N+1.
- Full throughput is 1 sample/cycle when the FIFO is non-empty and m_ready_i=1.
- Handshake: once m_valid_o=1, m_data_o and m_last_o hold until m_ready_i=1. m_valid_o never deasserts without a transfer, except on reset.
- A FIFO empty mid-frame stalls the frame. m_valid_o drops after the pending word transfers, and the frame resumes when data arrives.
- Reset mid-frame: the frame is abandoned with no m_last_o. The next cycle is IDLE and resumes draining.
- arm_i together with rst_i: reset wins.

## Configuration
- FIFO_READER_DECIM_EN defined:
  - decim_i port exists and is latched at arm.
  - In ARMED and CAPTURE, only every (decim+1)-th popped sample is kept; the phase counter clears at arm.
  - Discarded samples are popped with fifo_inc_o = !fifo_empty_i, regardless of the output slot.
  - Trigger comparison and capture count use kept samples only.
- FIFO_READER_DECIM_EN undefined: no decim_i port and no phase counter; every popped sample is kept.

## Structure
- Shared package fifo_reader_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE)
  - DATA_SIZE and LEN_SIZE defaults
- One sub-module, trig_detect: holds prev and prev_valid, and produces a combinational hit from prev, cur, level and polarity.

## Test plan
- Reset, then the FIFO holds 5 words with no arm -> fifo_inc_o high for 5 cycles, m_valid_o stays 0, busy_o=0.
- Arm with level=0x800, rising, len=4; feed 0x700,0x7FF,0x800,0x900,0xA00,0xB00 -> frame is 0x800,0x900,0xA00,0xB00 with m_last_o on 0xB00; then IDLE.
- Falling trigger, level=0x400; feed 0x500,0x400,0x300 with len=2 -> output 0x400,0x300.
- len=8, m_ready_i toggling 1-0-1-0 -> 8 transfers, data stable during stalls, no FIFO pop while stalled with m_valid_o=1.
- FIFO empties after the 3rd of 6 samples for 10 cycles -> frame resumes, exactly 6 samples, single m_last_o.
- With FIFO_READER_DECIM_EN, decim_i=1, ramp input 0,1,2,…; level=10, len=3 -> kept samples are the even values, trigger on 10, output 10,12,14.
